// File: rtl/j_tx_driver.sv
// j stream transmitter: host-filled byte FIFO drained one byte per valid pulse with a programmable gap.
// Optional per-packet checksum byte when J_TX_CKSUM_EN is defined.
module j_tx_driver #(
   parameter int DEPTH   = 8,
   parameter int GAPW    = 4,
   parameter int PKT_LEN = 4
) (
   input  logic            clock_i,
   input  logic            reset_ni,
   input  logic            wr_en_i,
   input  logic [7:0]      wr_data_i,
   input  logic            enable_i,
   input  logic [GAPW-1:0] gap_i,
   output logic            full_o,
   output logic            empty_o,
   output logic            overflow_o,
   output logic            valid_o,
   output logic [7:0]      j_o
);

   localparam int AW = $clog2(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || PKT_LEN < 1 || GAPW < 1) begin : g_bad_param
      $error("j_tx_driver: DEPTH must be a power of 2 >= 2, PKT_LEN and GAPW >= 1");
   end

`ifdef J_TX_CKSUM_EN
   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_CKSUM} state_t;
   localparam int CW = $clog2(PKT_LEN + 1);
   localparam logic [CW-1:0] PKT_CNT = CW'(PKT_LEN);
   logic [7:0]    sum_q, sum_d;
   logic [CW-1:0] cnt_q, cnt_d;
`else
   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;
`endif

   state_t          state_q, state_d;
   logic [AW:0]     wptr_q, rptr_q;
   logic [GAPW-1:0] gcnt_q, gcnt_d;
   logic            valid_q, valid_d;
   logic [7:0]      j_q, j_d;
   logic            ovf_q;
   logic [7:0]      mem [DEPTH];

   logic       full, empty, push, pop, slot;
   logic [7:0] head;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign push  = wr_en_i && !full;
   assign head  = mem[rptr_q[AW-1:0]];

   // NOTE: storage array has no reset; the pointers alone define which entries are live.
   always_ff @(posedge clock_i) begin
      if (push) mem[wptr_q[AW-1:0]] <= wr_data_i;
   end

   // NOTE: every variable gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      gcnt_d  = gcnt_q;
      valid_d = 1'b0;
      j_d     = j_q;
      pop     = 1'b0;
      slot    = 1'b0;
`ifdef J_TX_CKSUM_EN
      sum_d   = sum_q;
      cnt_d   = cnt_q;
`endif
      // A slot is the first edge at which a new byte may be launched.
      case (state_q)
         S_IDLE: slot = 1'b1;
         S_GAP: begin
            if (gcnt_q == GAPW'(1)) slot = 1'b1;
            else                    gcnt_d = gcnt_q - 1'b1;
         end
         default: begin
            if (gcnt_q == '0) slot = 1'b1;
            else              state_d = S_GAP;
         end
      endcase

      if (slot) begin
         state_d = S_IDLE;
`ifdef J_TX_CKSUM_EN
         if (cnt_q == PKT_CNT) begin
            state_d = S_CKSUM;
            valid_d = 1'b1;
            j_d     = sum_q;
            gcnt_d  = gap_i;
            sum_d   = '0;
            cnt_d   = '0;
         end else
`endif
         if (enable_i && !empty) begin
            pop     = 1'b1;
            state_d = S_SEND;
            valid_d = 1'b1;
            j_d     = head;
            gcnt_d  = gap_i;
`ifdef J_TX_CKSUM_EN
            sum_d   = sum_q + head;
            cnt_d   = cnt_q + CW'(1);
`endif
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= S_IDLE;
         wptr_q  <= '0;
         rptr_q  <= '0;
         gcnt_q  <= '0;
         valid_q <= 1'b0;
         j_q     <= 8'h00;
         ovf_q   <= 1'b0;
`ifdef J_TX_CKSUM_EN
         sum_q   <= '0;
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         gcnt_q  <= gcnt_d;
         valid_q <= valid_d;
         j_q     <= j_d;
         // A write into a full FIFO is dropped even if a pop frees a slot on the same edge.
         ovf_q   <= ovf_q | (wr_en_i && full);
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
`ifdef J_TX_CKSUM_EN
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign full_o     = full;
   assign empty_o    = empty;
   assign overflow_o = ovf_q;
   assign valid_o    = valid_q;
   assign j_o        = j_q;

endmodule

// File: tb/tb_j_tx_driver.sv
// Self-checking bench for j_tx_driver: directed scenarios plus random traffic against a slot-timing model.
module tb_j_tx_driver;
   localparam int DEPTH   = 8;
   localparam int GAPW    = 4;
   localparam int PKT_LEN = 4;

   logic            clock_i   = 1'b0;
   logic            reset_ni  = 1'b0;
   logic            wr_en_i   = 1'b0;
   logic [7:0]      wr_data_i = 8'h00;
   logic            enable_i  = 1'b0;
   logic [GAPW-1:0] gap_i     = '0;
   logic            full_o, empty_o, overflow_o, valid_o;
   logic [7:0]      j_o;

   j_tx_driver #(.DEPTH(DEPTH), .GAPW(GAPW), .PKT_LEN(PKT_LEN)) dut (
      .clock_i(clock_i), .reset_ni(reset_ni), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
      .enable_i(enable_i), .gap_i(gap_i), .full_o(full_o), .empty_o(empty_o),
      .overflow_o(overflow_o), .valid_o(valid_o), .j_o(j_o)
   );

   always #5 clock_i = ~clock_i;

   int total = 0;
   int bad   = 0;

   // Model: queue of stored bytes; an emission may happen at any edge index >= ready,
   // after which the next one is allowed gap+1 edges later.
   byte unsigned mq[$];
   int           ec    = 0;
   int           ready = 0;
   logic         m_valid = 1'b0;
   logic [7:0]   m_j     = 8'h00;
   logic         m_ovf   = 1'b0;
   logic [7:0]   m_sum   = 8'h00;
   int           m_cnt   = 0;

   task automatic model_reset();
      mq.delete();
      ready   = 0;
      m_valid = 1'b0;
      m_j     = 8'h00;
      m_ovf   = 1'b0;
      m_sum   = 8'h00;
      m_cnt   = 0;
   endtask

   task automatic model_edge();
      int pre;
      pre = mq.size();
      ec++;
      m_valid = 1'b0;
      if (ec >= ready) begin
`ifdef J_TX_CKSUM_EN
         if (m_cnt == PKT_LEN) begin
            m_valid = 1'b1;
            m_j     = m_sum;
            m_sum   = 8'h00;
            m_cnt   = 0;
         end else
`endif
         if (enable_i && pre > 0) begin
            m_valid = 1'b1;
            m_j     = mq.pop_front();
            m_sum   = m_sum + m_j;
            m_cnt++;
         end
         if (m_valid) ready = ec + 1 + int'(gap_i);
      end
      if (wr_en_i) begin
         if (pre == DEPTH) m_ovf = 1'b1;
         else              mq.push_back(wr_data_i);
      end
   endtask

   function automatic logic [11:0] obs();
      return {valid_o, j_o, full_o, empty_o, overflow_o};
   endfunction

   function automatic logic [11:0] expv();
      return {m_valid, m_j, mq.size() == DEPTH, mq.size() == 0, m_ovf};
   endfunction

   task automatic step(input logic we, input logic [7:0] d, input logic en, input logic [GAPW-1:0] g);
      @(negedge clock_i);
      wr_en_i = we; wr_data_i = d; enable_i = en; gap_i = g;
      @(posedge clock_i);
      if (reset_ni) model_edge();
      else          model_reset();
      #1;
   endtask

   task automatic do_reset();
      @(negedge clock_i);
      reset_ni = 1'b0;
      model_reset();
      step(1'b0, 8'h00, 1'b0, '0);
      step(1'b0, 8'h00, 1'b0, '0);
      @(negedge clock_i);
      reset_ni = 1'b1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 8'($urandom), 1'b1, '0);
         total++;
         if (obs() !== 12'h002) begin
            bad++;
            $display("FAIL reset cyc%0d got=%h exp=002 (v,j,full,empty,ovf)", i, obs());
         end
      end
      @(negedge clock_i);
      reset_ni = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      step(1'b1, 8'hA5, 1'b1, '0);
      total++;
      if (valid_o !== 1'b0) begin bad++; $display("FAIL single_early got v=%b exp v=0", valid_o); end
      step(1'b0, 8'h00, 1'b1, '0);
      total++;
      if ({valid_o, j_o} !== {1'b1, 8'hA5}) begin
         bad++; $display("FAIL single_emit got v=%b j=%h exp v=1 j=a5", valid_o, j_o);
      end
      step(1'b0, 8'h00, 1'b1, '0);
      total++;
      if ({valid_o, empty_o} !== 2'b01) begin
         bad++; $display("FAIL single_after got v=%b empty=%b exp v=0 empty=1", valid_o, empty_o);
      end
   endtask

   // Pushes three bytes with the given gap and checks contents and spacing of emissions.
   task automatic run_gap(input logic [GAPW-1:0] g, input string nm);
      byte unsigned vals[3] = '{8'h11, 8'h22, 8'h33};
      int t_q[$];
      byte unsigned b_q[$];
      do_reset();
      for (int i = 0; i < 3 + 15; i++) begin
         if (i < 3) step(1'b1, vals[i], 1'b1, g);
         else       step(1'b0, 8'h00, 1'b1, g);
         total++;
         if (obs() !== expv()) begin
            bad++; $display("FAIL %s_cyc%0d got=%h exp=%h", nm, i, obs(), expv());
         end
         if (valid_o) begin t_q.push_back(i); b_q.push_back(j_o); end
      end
      total++;
      if (b_q.size() != 3) begin
         bad++; $display("FAIL %s_count got=%0d exp=3", nm, b_q.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            total++;
            if (b_q[k] != vals[k]) begin
               bad++; $display("FAIL %s_byte%0d got=%h exp=%h", nm, k, b_q[k], vals[k]);
            end
            if (k > 0) begin
               total++;
               if (t_q[k] - t_q[k-1] != int'(g) + 1) begin
                  bad++; $display("FAIL %s_spacing%0d got=%0d exp=%0d", nm, k, t_q[k] - t_q[k-1], int'(g) + 1);
               end
            end
         end
      end
   endtask

   task automatic test_gap();
      run_gap(GAPW'(2), "gap2");
      run_gap(GAPW'(0), "gap0");
   endtask

   task automatic test_overflow();
      byte unsigned b[9];
      byte unsigned exp_q[$];
      byte unsigned got_q[$];
      logic [7:0] s;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         b[i] = 8'($urandom);
         step(1'b1, b[i], 1'b0, '0);
         if (i == 7) begin
            total++;
            if ({full_o, overflow_o} !== 2'b10) begin
               bad++; $display("FAIL ovf_full8 got full=%b ovf=%b exp full=1 ovf=0", full_o, overflow_o);
            end
         end
      end
      total++;
      if ({full_o, overflow_o} !== 2'b11) begin
         bad++; $display("FAIL ovf_sticky got full=%b ovf=%b exp full=1 ovf=1", full_o, overflow_o);
      end
      s = 8'h00;
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(b[i]);
         s = s + b[i];
`ifdef J_TX_CKSUM_EN
         if ((i + 1) % PKT_LEN == 0) begin exp_q.push_back(s); s = 8'h00; end
`endif
      end
      for (int i = 0; i < 24; i++) begin
         step(1'b0, 8'h00, 1'b1, '0);
         total++;
         if (obs() !== expv()) begin
            bad++; $display("FAIL ovf_drain_cyc%0d got=%h exp=%h", i, obs(), expv());
         end
         if (valid_o) got_q.push_back(j_o);
      end
      total++;
      if (got_q != exp_q) begin
         bad++; $display("FAIL ovf_order got %0d bytes exp %0d bytes (first got=%h exp=%h)",
                         got_q.size(), exp_q.size(), got_q.size() ? got_q[0] : 8'h00, exp_q[0]);
      end
   endtask

   task automatic test_reset_mid_gap();
      bit seen;
      int nval;
      do_reset();
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step(i < 4, 8'h40 + 8'(i), 1'b1, GAPW'(5));
         if (valid_o) seen = 1'b1;
      end
      for (int i = 0; i < 2; i++) step(1'b1, 8'h4C + 8'(i), 1'b1, GAPW'(5));
      total++;
      if (!seen || valid_o !== 1'b0) begin
         bad++; $display("FAIL midgap_setup got seen=%0b v=%b exp seen=1 v=0", seen, valid_o);
      end
      #2;
      reset_ni = 1'b0;
      #1;
      model_reset();
      total++;
      if ({valid_o, empty_o, j_o} !== {1'b0, 1'b1, 8'h00}) begin
         bad++; $display("FAIL midgap_async got v=%b empty=%b j=%h exp v=0 empty=1 j=00", valid_o, empty_o, j_o);
      end
      step(1'b0, 8'h00, 1'b1, '0);
      step(1'b0, 8'h00, 1'b1, '0);
      @(negedge clock_i);
      reset_ni = 1'b1;
      nval = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 8'h00, 1'b1, '0);
         if (valid_o) nval++;
      end
      total++;
      if (nval != 0 || empty_o !== 1'b1) begin
         bad++; $display("FAIL midgap_after got valids=%0d empty=%b exp valids=0 empty=1", nval, empty_o);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 800; i++) begin
         step(($urandom % 3) != 0, 8'($urandom), ($urandom % 4) != 0,
              (($urandom % 8) == 0) ? GAPW'($urandom) : GAPW'($urandom_range(0, 2)));
         total++;
         if (obs() !== expv()) begin
            bad++; $display("FAIL random_cyc%0d got=%h exp=%h", i, obs(), expv());
         end
      end
   endtask

`ifdef J_TX_CKSUM_EN
   task automatic test_cksum();
      byte unsigned pk[8] = '{8'h01, 8'h02, 8'h03, 8'hFF, 8'h10, 8'h20, 8'h30, 8'h40};
      byte unsigned exp_q[$] = '{8'h01, 8'h02, 8'h03, 8'hFF, 8'h05};
      byte unsigned got_q[$];
      int t_q[$];
      do_reset();
      for (int p = 0; p < 2; p++) begin
         got_q.delete();
         t_q.delete();
         for (int i = 0; i < 4; i++) step(1'b1, pk[4*p + i], 1'b0, '0);
         for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'h00, 1'b1, '0);
            total++;
            if (obs() !== expv()) begin
               bad++; $display("FAIL cksum_p%0d_cyc%0d got=%h exp=%h", p, i, obs(), expv());
            end
            if (valid_o) begin got_q.push_back(j_o); t_q.push_back(i); end
         end
         total++;
         if (got_q != exp_q || t_q.size() != 5 || t_q[4] - t_q[0] != 4) begin
            bad++; $display("FAIL cksum_p%0d got %0d bytes last=%h exp 5 consecutive last=%h",
                            p, got_q.size(), got_q.size() ? got_q[got_q.size()-1] : 8'h00, exp_q[4]);
         end
         exp_q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'hA0};
      end
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_gap();
      test_overflow();
      test_reset_mid_gap();
`ifdef J_TX_CKSUM_EN
      test_cksum();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
